// File: rtl/rr_arb8.sv
// rr_arb8: eight-way round-robin arbiter with a registered one-hot grant.
// A grant is held until ACK, until the requester withdraws, or until
// TIMEOUT cycles have elapsed. Priority then rotates past the last winner.

// Per-requester arbitration cell. A requester wins when it is requesting and
// no other active requester sits closer to the pointer in rotation order.
module rr_arb8_lane #(
  parameter int IDX = 0
) (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic       win
);
  localparam logic [2:0] ME = 3'(IDX);

  logic [2:0] my_dist;

  // Rotation distance from the pointer, modulo 8 via 3-bit wrap.
  assign my_dist = ME - ptr;

  // Lose to any active requester that is strictly nearer the pointer.
  always_comb begin
    win = req[IDX];
    for (int j = 0; j < 8; j++) begin
      if (req[j] && ((3'(j) - ptr) < my_dist)) win = 1'b0;
    end
  end
endmodule

module rr_arb8 #(
  parameter int TIMEOUT = 15
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] REQ,
  input  logic       ACK,
  output logic [7:0] GNT,
  output logic       GNT_VALID,
  output logic       TMO
);
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          vld_q;
  logic [7:0]    win;
  logic [2:0]    gidx;
  logic          held;
  logic          expired;

  // One arbitration cell per requester; exactly one wins when REQ != 0.
  for (genvar i = 0; i < 8; i++) begin : g_lane
    rr_arb8_lane #(.IDX(i)) u_lane (
      .req (REQ),
      .ptr (ptr_q),
      .win (win[i])
    );
  end

  // Index of the currently granted requester (grant is one-hot).
  always_comb begin
    gidx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (gnt_q[i]) gidx = 3'(i);
    end
  end

  assign held    = |(REQ & gnt_q);
  assign expired = (cnt_q == CNT_LAST);

  // Next-state logic: arbitrate in IDLE, evaluate release conditions in GRANT.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          gnt_d   = win;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // ACK beats withdrawal, which beats timeout; only a pure timeout
        // produces the TMO pulse.
        if (ACK || !held || expired) begin
          gnt_d   = 8'h00;
          ptr_d   = gidx + 3'd1;
          state_d = IDLE;
          tmo_d   = !ACK && held && expired;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 8'h00;
      end
    endcase
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      gnt_q   <= 8'h00;
      vld_q   <= 1'b0;
      ptr_q   <= 3'd0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= |gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign GNT       = gnt_q;
  assign GNT_VALID = vld_q;
  assign TMO       = tmo_q;
endmodule

// File: tb/tb_rr_arb8.sv
// Directed bench for rr_arb8 with a grant scoreboard. Stimulus pushes the
// expected grant (vector, length in cycles, timeout flag); the monitor pops
// one entry each time a grant ends and compares.
module tb_rr_arb8;
  logic       CLK;
  logic       RST_N;
  logic [7:0] REQ;
  logic       ACK;
  logic [7:0] GNT;
  logic       GNT_VALID;
  logic       TMO;

  typedef struct {
    logic [7:0] gnt;
    int         len;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  rr_arb8 #(.TIMEOUT(15)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .REQ       (REQ),
    .ACK       (ACK),
    .GNT       (GNT),
    .GNT_VALID (GNT_VALID),
    .TMO       (TMO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    end
  endtask

  task automatic push(input logic [7:0] g, input int len, input logic t);
    exp_t e;
    e.gnt = g;
    e.len = len;
    e.tmo = t;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Monitor: track each grant from rise to fall, compare against the queue.
  logic [7:0] cur_gnt;
  int         cur_len;
  logic       in_g;
  initial in_g = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      in_g = 1'b0;
    end else begin
      check("valid_eq_or", 32'(GNT_VALID), 32'(|GNT));
      check("onehot0", 32'($onehot0(GNT)), 32'd1);
      if (GNT_VALID) begin
        if (!in_g) begin
          in_g    = 1'b1;
          cur_gnt = GNT;
          cur_len = 0;
        end
        cur_len++;
        check("gnt_stable", 32'(GNT), 32'(cur_gnt));
        check("tmo_in_grant", 32'(TMO), 32'd0);
      end else if (in_g) begin
        exp_t e;
        in_g = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_grant", 32'(cur_gnt), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("grant_vec", 32'(cur_gnt), 32'(e.gnt));
          check("grant_len", 32'(cur_len), 32'(e.len));
          check("release_tmo", 32'(TMO), 32'(e.tmo));
        end
      end else begin
        check("tmo_idle", 32'(TMO), 32'd0);
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    REQ   = 8'hFF;
    ACK   = 1'b1;
    step(2);
    check("rst_gnt", 32'(GNT), 32'h00);
    check("rst_valid", 32'(GNT_VALID), 32'd0);
    check("rst_tmo", 32'(TMO), 32'd0);

    // Round robin: all requesting, ACK every grant -> grant every other cycle.
    for (int i = 0; i < 8; i++) push(8'h01 << i, 1, 1'b0);
    push(8'h01, 1, 1'b0);
    RST_N = 1'b1;
    step(1);
    check("first_after_rst", 32'(GNT), 32'h01);
    step(17);

    // Grant bit 5 so the pointer lands on 6, then wrap to 0 and back to 5.
    REQ = 8'h20;
    push(8'h20, 1, 1'b0);
    step(2);
    REQ = 8'h21;
    push(8'h01, 1, 1'b0);
    push(8'h20, 1, 1'b0);
    step(4);

    // Timeout: 15-cycle grant with TMO, then immediate regrant that is
    // withdrawn in its third cycle.
    REQ = 8'h08;
    ACK = 1'b0;
    push(8'h08, 15, 1'b1);
    push(8'h08, 3, 1'b0);
    step(16);
    check("tmo_pulse", 32'(TMO), 32'd1);
    step(3);
    REQ = 8'h00;
    step(1);
    check("withdraw_release", 32'(GNT), 32'h00);
    step(2);

    // ACK in cycle 15 collides with timeout: ACK wins, no TMO.
    REQ = 8'h08;
    push(8'h08, 15, 1'b0);
    step(15);
    ACK = 1'b1;
    step(1);
    ACK = 1'b0;
    REQ = 8'h00;
    step(1);
    check("collision_tmo", 32'(TMO), 32'd0);
    step(1);

    // Async reset while bit 4 is granted (pointer is 4 here).
    REQ = 8'h10;
    step(1);
    check("pre_rst_gnt", 32'(GNT), 32'h10);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_gnt", 32'(GNT), 32'h00);
    check("async_rst_valid", 32'(GNT_VALID), 32'd0);
    step(1);
    REQ = 8'hFF;
    ACK = 1'b1;
    #2;
    RST_N = 1'b1;
    push(8'h01, 1, 1'b0);
    step(1);
    check("restart_ptr0", 32'(GNT), 32'h01);
    REQ = 8'h00;
    step(3);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rr_arb8.md
# rr_arb8

Eight-way round-robin request arbiter that sits directly upstream of the 8-to-3 encoder. It samples eight independent request lines and issues at most one grant at a time as a one-hot vector (`GNT`), which drives the encoder's `IN` bus directly. A grant is held until the consumer acknowledges it, the requester withdraws, or a programmable timeout expires. Priority then rotates so that no requester is starved.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum number of cycles a grant may be held. Legal range is 1..255.

Ports:
- `CLK`  input  1  single clock; all state updates on the rising edge.
- `RST_N`  input  1  reset, asynchronous assert, active-low.
- `REQ`  input  8  request lines; bit i high means requester i wants service. Level-sensitive.
- `ACK`  input  1  consumer done with the current grant. Ignored while no grant is active.
- `GNT`  output  8  registered one-hot grant; all-zero when idle. Feeds the encoder `IN`.
- `GNT_VALID`  output  1  registered; high exactly when `GNT` is non-zero.
- `TMO`  output  1  registered; one-cycle pulse when a grant is released by timeout.

## Operation
- Reset (`RST_N` low, asynchronous): the block is forced to the following state, and it applies immediately even in mid-grant.
  - state = IDLE
  - `GNT` = 8'h00, `GNT_VALID` = 0, `TMO` = 0
  - pointer `PTR` = 3'd0, hold counter = 0
- Internal state:
  - 2-state FSM: IDLE, GRANT.
  - 3-bit `PTR`: the highest-priority index for the next arbitration.
  - Hold counter of width $clog2(TIMEOUT+1).
- IDLE:
  - If `REQ` == 0, stay in IDLE with outputs zero.
  - Otherwise select the first index i with `REQ[i]` = 1, searching `PTR`, `PTR`+1, … modulo 8 (wraps 7 → 0).
  - Load `GNT` = 1<<i, set `GNT_VALID` = 1, clear the counter, go to GRANT.
- GRANT: evaluate the release conditions each cycle, in this priority order.
  - (a) `ACK` = 1: release with `TMO` = 0.
  - (b) `REQ[g]` = 0, where g is the granted index: release with `TMO` = 0 (requester withdrew).
  - (c) counter == `TIMEOUT`-1: release with `TMO` = 1.
  - Otherwise stay in GRANT; the counter increments and `GNT` holds its value.
- Release:
  - Set `GNT` = 0 and `GNT_VALID` = 0, go to IDLE.
  - Set `PTR` = g+1 modulo 8 (index 7 → 0).
- Requests on bits other than g are ignored while in GRANT. They are re-evaluated in IDLE.
- `GNT` is never multi-hot. `GNT_VALID` always equals |`GNT`.

## Timing
- Grant latency: `REQ` sampled high at edge N while IDLE gives `GNT`/`GNT_VALID` high from edge N through the cycle following it.
- Hold time:
  - `GNT` stays high for at least 1 and at most `TIMEOUT` cycles.
  - Cycle k of the grant (k = 1..`TIMEOUT`) has counter = k-1.
- Release latency: a release condition sampled at edge M means `GNT` = 0 after edge M.
- Idle gap: there is always at least one cycle with `GNT` = 0 between consecutive grants, including when requests are continuously asserted.
  - With all `REQ` high and `ACK` tied high, the block grants every other cycle.
- `TMO` timing: high for exactly the one cycle after the releasing edge, which is the first IDLE cycle. It is 0 in all other cycles.
- Simultaneous conditions:
  - `ACK` together with timeout: `ACK` wins and no `TMO` pulse is generated.
  - `ACK` together with `REQ[g]` dropping: normal release, `TMO` = 0.
- `TIMEOUT` = 1: every grant lasts exactly one cycle. `TMO` pulses unless `ACK` = 1 or `REQ[g]` = 0 in that cycle.
- Reset asserted mid-grant: `GNT` drops asynchronously. After `RST_N` deasserts, arbitration restarts from `PTR` = 0.

## Test plan
- Reset with `REQ` = 8'hFF: `GNT` = 0, `GNT_VALID` = 0, `TMO` = 0. On the first edge after deassert, `GNT` = 8'h01.
- Round-robin fairness:
  - Stimulus: `REQ` = 8'hFF, `ACK` high in every grant cycle.
  - Required grant sequence: 01, 02, 04, 08, 10, 20, 40, 80, 01, … with a zero cycle between each grant.
- Wrap and skip:
  - Stimulus: `PTR` = 6 (after granting bit 5), then `REQ` = 8'h21.
  - Required: the next grant is 8'h01, and the grant after that is 8'h20.
- Timeout:
  - Stimulus: `TIMEOUT` = 15, `REQ` = 8'h08, `ACK` = 0.
  - Required: `GNT` = 8'h08 for exactly 15 cycles, then `TMO` high for 1 cycle. The following grant is 8'h08 again.
- Withdraw and collision:
  - Stimulus: requester drops `REQ[g]` in grant cycle 3.
  - Required: release after that edge with `TMO` = 0.
  - Stimulus: `ACK` asserted in cycle 15 when `TIMEOUT` = 15.
  - Required: release with no `TMO` pulse.
- Async reset mid-grant: assert `RST_N` low between edges while `GNT` = 8'h10. `GNT` must go to 0 before the next edge.
